muldiv_seq: RTL
===============

# muldiv_seq

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts one M-extension operation from E, runs a fixed 32-iteration shift-add multiply or restoring divide, and holds the pipeline with a stall request until the result is ready. In the completion cycle the execute stage selects the result in place of the ALU result, and the instruction advances to M normally.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- startE  in  1  the instruction in E is an M-extension op. Held high while the instruction stays in E.
- funct3E  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcAE  in  XLEN  forwarded rs1 value.
- srcBE  in  XLEN  forwarded rs2 value.
- killE  in  1  abort the in-flight op (trap/flush of E).
- stallE  out  1  hold IF/ID/E and bubble M.
- busyE  out  1  sequencer is not in IDLE.
- doneE  out  1  resultE is valid this cycle.
- resultE  out  XLEN  operation result.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with startE=1 and killE=0:
  - latch funct3, the operand magnitudes, and the result-sign and remainder-sign flags;
  - clear the accumulator and set the iteration counter to 0;
  - go to CALC.
- CALC:
  - one iteration per cycle;
  - multiply: shift-add over a 2·XLEN product register;
  - divide: restoring shift-subtract over {remainder, quotient};
  - counter 0..ITER-1; at ITER-1 go to DONE.
- DONE:
  - apply sign fix-up, drive resultE, doneE=1;
  - go to IDLE unconditionally, even if startE is still high, because the same instruction is leaving E.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Magnitudes are taken with two's-complement negation; the result is negated when the sign flag is set.
- Result select:
  - MUL: low word of the product.
  - MULH/MULHSU/MULHU: high word of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; the remainder sign follows the dividend.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU), remainder = dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Both special cases are detected at capture and forced in DONE. Latency is unchanged.
- killE in any state: next state IDLE, no doneE, result discarded. killE has priority over startE.

## Timing
- Reset values:
  - state IDLE, counter 0, all datapath registers 0;
  - doneE=0, resultE=0, busyE=0;
  - stallE=0 (startE=0 during reset).
- stallE = startE & ~killE & (state != DONE). It is combinational so the capture cycle is already stalled.
- busyE and doneE are decoded from registered state.
- Start seen at cycle 0 (IDLE, stallE=1); CALC occupies cycles 1..32 (stallE=1); DONE at cycle 33 (stallE=0, doneE=1). The instruction leaves E at the end of cycle 33.
- Back-to-back ops: the next instruction enters E at cycle 34, with the FSM in IDLE, and is captured that cycle. No dead cycle.
- Operands are sampled only in the capture cycle. Forwarding changes during CALC are ignored.
- Async reset mid-operation: immediately returns to IDLE; outputs return to their reset values.

## Structure
- Shared package muldiv_pkg:
  - XLEN, ITER constants;
  - funct3 op localparams;
  - state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- Sub-module muldiv_step: purely combinational single iteration. Inputs: mode and current accumulator. Output: next accumulator for either add-shift or subtract-shift. Instantiated once.
- Top level: FSM, counter, operand/sign capture, fix-up.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → resultE=0xFFFFFFEB at cycle 33; stallE high cycles 0–32.
- MULH/MULHSU/MULHU of 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 with REM 0. Latency 33 in all cases.
- killE at CALC cycle 10 → IDLE next cycle, doneE never asserted; a following MUL 3×4 returns 12 with normal latency.
- rst_n low at cycle 15 of a DIVU → all outputs 0 asynchronously; back-to-back MUL then DIVU after release both complete with no gap cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M sequencer.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return !(f3 == OP_MULHU || f3 == OP_DIVU || f3 == OP_REMU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == OP_MUL || f3 == OP_MULH || f3 == OP_DIV || f3 == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply on {hi, multiplier} or
// restoring shift-subtract divide on {remainder, quotient}.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_sub;
    logic            fits;

    always_comb begin
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_i[0]}} & {1'b0, opnd_i});
        rem_sh  = acc_i[2*XLEN-1:XLEN-1];
        fits    = (rem_sh >= {1'b0, opnd_i});
        // Difference is below the divisor when it fits, so XLEN bits suffice.
        rem_sub = rem_sh[XLEN-1:0] - opnd_i;
        if (div_i) begin
            acc_o = fits ? {rem_sub, acc_i[XLEN-2:0], 1'b1} : {acc_i[2*XLEN-2:0], 1'b0};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Capture in IDLE, ITER iterations in CALC, sign fix-up and result in DONE.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            startE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] srcAE,
    input  logic [XLEN-1:0] srcBE,
    input  logic            killE,
    output logic            stallE,
    output logic            busyE,
    output logic            doneE,
    output logic [XLEN-1:0] resultE
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(ITER);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic              div0_q, div0_d, ovf_q, ovf_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, res;

    assign a_neg = op_a_signed(funct3E) & srcAE[XLEN-1];
    assign b_neg = op_b_signed(funct3E) & srcBE[XLEN-1];
    assign a_mag = a_neg ? -srcAE : srcAE;
    assign b_mag = b_neg ? -srcBE : srcBE;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i  (op_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (startE && !killE) begin
                    // Multiply keeps the multiplier in the low half, divide the dividend.
                    op_d    = funct3E;
                    acc_d   = {{XLEN{1'b0}}, funct3E[2] ? a_mag : b_mag};
                    opnd_d  = funct3E[2] ? b_mag : a_mag;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    div0_d  = (srcBE == '0);
                    ovf_d   = funct3E[2] & op_b_signed(funct3E) & (&srcBE)
                              & (srcAE == {1'b1, {(XLEN-1){1'b0}}});
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER-1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (killE) state_d = IDLE;
    end

    // A zero divisor leaves the dividend magnitude in the remainder half naturally.
    assign prod = neg_q ? -acc_q : acc_q;
    assign quot = div0_q ? {XLEN{1'b1}} :
                  ovf_q  ? {1'b1, {(XLEN-1){1'b0}}} :
                  (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    assign rem  = ovf_q  ? '0 :
                  (rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]);

    always_comb begin
        res = '0;
        unique case (op_q)
            OP_MUL:                       res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res = quot;
            default:                      res = rem;
        endcase
    end

    assign doneE   = (state_q == DONE);
    assign busyE   = (state_q != IDLE);
    assign stallE  = startE & ~killE & (state_q != DONE);
    assign resultE = doneE ? res : '0;

endmodule
